// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a
// strobe-held, fixed-latency sdram model with no acknowledge.
module cache_ctrl #(
    parameter int unsigned INDEX_BITS  = 5,
    parameter int unsigned OFFSET_BITS = 3,
    parameter int unsigned MEM_DELAY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cs,
    input  logic        cpu_wr_rd,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic        mem_wr_rd,
    output logic        mem_strb,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned TAG_W      = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned LINES      = 1 << INDEX_BITS;
    localparam int unsigned LINE_BYTES = 1 << OFFSET_BITS;
    localparam int unsigned CYC_W      = $clog2(MEM_DELAY + 2);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     wr_q;
    logic [7:0]               din_q;
    logic                     first_q;
    logic [LINES-1:0]         valid_q;
    logic [LINES-1:0]         dirty_q;
    logic [OFFSET_BITS-1:0]   byte_q;
    logic [CYC_W-1:0]         cyc_q;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [7:0]               data_q [LINES*LINE_BYTES];

    logic [TAG_W-1:0]         tag_l;
    logic [INDEX_BITS-1:0]    idx_l;
    logic [OFFSET_BITS-1:0]   off_l;
    logic                     hit_c;
    logic                     beat_end_c;
    logic                     last_byte_c;
    logic [OFFSET_BITS-1:0]   next_byte_c;

    assign tag_l       = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_l       = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign off_l       = addr_q[OFFSET_BITS-1:0];
    assign hit_c       = valid_q[idx_l] && (tag_q[idx_l] == tag_l);
    assign beat_end_c  = (cyc_q == CYC_W'(MEM_DELAY + 1));
    assign last_byte_c = (byte_q == {OFFSET_BITS{1'b1}});
    assign next_byte_c = byte_q + OFFSET_BITS'(1);

    // Line storage carries no reset; only valid/dirty need a known state.
    always_ff @(posedge clk) begin
        if (state_q == COMPARE && hit_c && wr_q) begin
            data_q[{idx_l, off_l}] <= din_q;
        end else if (state_q == ALLOCATE && beat_end_c) begin
            data_q[{idx_l, byte_q}] <= mem_din;
        end
        if (state_q == ALLOCATE && beat_end_c && last_byte_c) begin
            tag_q[idx_l] <= tag_l;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            din_q     <= '0;
            first_q   <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
            byte_q    <= '0;
            cyc_q     <= '0;
            cpu_rdy   <= 1'b1;
            cpu_dout  <= '0;
            mem_addr  <= '0;
            mem_wr_rd <= 1'b0;
            mem_strb  <= 1'b0;
            mem_dout  <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_cs) begin
                        addr_q  <= cpu_addr;
                        wr_q    <= cpu_wr_rd;
                        din_q   <= cpu_din;
                        first_q <= 1'b1;
                        cpu_rdy <= 1'b0;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    first_q <= 1'b0;
                    if (hit_c) begin
                        if (wr_q) begin
                            dirty_q[idx_l] <= 1'b1;
                        end else begin
                            cpu_dout <= data_q[{idx_l, off_l}];
                        end
                        if (first_q && hit_cnt != 16'hFFFF) begin
                            hit_cnt <= hit_cnt + 16'd1;
                        end
                        cpu_rdy <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        if (miss_cnt != 16'hFFFF) begin
                            miss_cnt <= miss_cnt + 16'd1;
                        end
                        byte_q   <= '0;
                        cyc_q    <= '0;
                        mem_strb <= 1'b1;
                        if (valid_q[idx_l] && dirty_q[idx_l]) begin
                            mem_wr_rd <= 1'b1;
                            mem_addr  <= {tag_q[idx_l], idx_l, {OFFSET_BITS{1'b0}}};
                            mem_dout  <= data_q[{idx_l, {OFFSET_BITS{1'b0}}}];
                            state_q   <= WRITEBACK;
                        end else begin
                            mem_wr_rd <= 1'b0;
                            mem_addr  <= {tag_l, idx_l, {OFFSET_BITS{1'b0}}};
                            state_q   <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK, ALLOCATE: begin
                    // Each byte: strobe high MEM_DELAY+1 cycles, then one low cycle.
                    if (!beat_end_c) begin
                        cyc_q    <= cyc_q + CYC_W'(1);
                        mem_strb <= (cyc_q < CYC_W'(MEM_DELAY));
                    end else begin
                        cyc_q <= '0;
                        if (!last_byte_c) begin
                            byte_q   <= next_byte_c;
                            mem_strb <= 1'b1;
                            mem_addr[OFFSET_BITS-1:0] <= next_byte_c;
                            if (state_q == WRITEBACK) begin
                                mem_dout <= data_q[{idx_l, next_byte_c}];
                            end
                        end else begin
                            byte_q <= '0;
                            if (state_q == WRITEBACK) begin
                                dirty_q[idx_l] <= 1'b0;
                                mem_strb       <= 1'b1;
                                mem_wr_rd      <= 1'b0;
                                mem_addr       <= {tag_l, idx_l, {OFFSET_BITS{1'b0}}};
                                state_q        <= ALLOCATE;
                            end else begin
                                valid_q[idx_l] <= 1'b1;
                                dirty_q[idx_l] <= 1'b0;
                                state_q        <= COMPARE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: sdram model, transaction-level cache model,
// per-strobe protocol monitor and a few literal expectations.
module tb_cache_ctrl;

    localparam int MEM_DELAY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cs;
    logic        cpu_wr_rd;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic        mem_wr_rd;
    logic        mem_strb;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    cache_ctrl #(.INDEX_BITS(5), .OFFSET_BITS(3), .MEM_DELAY(MEM_DELAY)) dut (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_wr_rd(cpu_wr_rd), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
        .mem_addr(mem_addr), .mem_wr_rd(mem_wr_rd), .mem_strb(mem_strb),
        .mem_dout(mem_dout), .mem_din(mem_din),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        if (a >= 16'h1230 && a <= 16'h1237) return 8'h10 + {5'd0, a[2:0]};
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // sdram model
    logic [7:0] sdram [65536];
    bit init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) sdram[i] <= pat(16'(i));
            init_done <= 1'b1;
        end else if (mem_strb && mem_wr_rd) begin
            sdram[mem_addr] <= mem_dout;
        end
        mem_din <= sdram[mem_addr];
    end

    // Strobe monitor: logs each access and checks its shape
    logic [24:0] log_q[$];
    int          run = 0;
    logic [15:0] run_addr;
    logic        run_wr;
    logic [7:0]  run_dat;
    bit          run_ok;
    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else if (mem_strb) begin
            if (run == 0) begin
                run_addr = mem_addr; run_wr = mem_wr_rd; run_dat = mem_dout; run_ok = 1'b1;
                log_q.push_back({mem_wr_rd, mem_addr, mem_wr_rd ? mem_dout : 8'h00});
            end else if (mem_addr != run_addr || mem_wr_rd != run_wr || mem_dout != run_dat) begin
                run_ok = 1'b0;
            end
            run++;
        end else if (run != 0) begin
            checks++;
            if (run != MEM_DELAY + 1 || !run_ok) begin
                failures++;
                $display("FAIL strobe_run addr=%h: len=%0d stable=%0d, expected len=%0d stable=1",
                         run_addr, run, run_ok, MEM_DELAY + 1);
            end
            run = 0;
        end
    end

    // Cache model
    bit         m_valid [32];
    bit         m_dirty [32];
    logic [7:0] m_tag   [32];
    logic [7:0] m_data  [256];
    logic [7:0] shadow  [65536];
    int         m_hit, m_miss;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        m_hit = 0; m_miss = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req(input bit wr, input logic [15:0] a, input logic [7:0] d,
                       input bit hold, output int lat);
        logic [4:0]  idx;
        logic [7:0]  tg;
        logic [24:0] exp_q[$];
        logic [7:0]  exp_dout;
        int          exp_lat;
        int          base;
        idx = a[7:3]; tg = a[15:8];
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_lat = 1;
            if (m_hit < 65535) m_hit++;
        end else begin
            if (m_miss < 65535) m_miss++;
            exp_lat = 2 + 8 * (MEM_DELAY + 2);
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_lat += 8 * (MEM_DELAY + 2);
                for (int b = 0; b < 8; b++) begin
                    exp_q.push_back({1'b1, m_tag[idx], idx, 3'(b), m_data[{idx, 3'(b)}]});
                    shadow[{m_tag[idx], idx, 3'(b)}] = m_data[{idx, 3'(b)}];
                end
            end
            for (int b = 0; b < 8; b++) begin
                exp_q.push_back({1'b0, tg, idx, 3'(b), 8'h00});
                m_data[{idx, 3'(b)}] = shadow[{tg, idx, 3'(b)}];
            end
            m_tag[idx] = tg; m_valid[idx] = 1; m_dirty[idx] = 0;
        end
        if (wr) begin
            m_data[a[7:0]] = d; m_dirty[idx] = 1;
        end
        exp_dout = m_data[a[7:0]];

        base = log_q.size();
        @(negedge clk);
        cpu_cs = 1'b1; cpu_wr_rd = wr; cpu_addr = a; cpu_din = d;
        @(posedge clk); #1;
        if (hold) begin
            cpu_addr = a ^ 16'h4000; cpu_wr_rd = 1'b1; cpu_din = 8'hEE;
        end else begin
            cpu_cs = 1'b0;
        end
        lat = 0;
        while (cpu_rdy !== 1'b1 && lat < 200) begin
            lat++;
            @(posedge clk); #1;
        end
        cpu_cs = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        if (!wr) check("cpu_dout", {24'd0, cpu_dout}, {24'd0, exp_dout});
        check("hit_cnt", {16'd0, hit_cnt}, 32'(m_hit));
        check("miss_cnt", {16'd0, miss_cnt}, 32'(m_miss));
        check("mem_access_count", 32'(log_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                check($sformatf("mem_access[%0d]", i), {7'd0, log_q[base + i]}, {7'd0, exp_q[i]});
        end
    endtask

    int lat;

    initial begin
        rst = 1'b1; cpu_cs = 1'b0; cpu_wr_rd = 1'b0; cpu_addr = '0; cpu_din = '0;
        for (int i = 0; i < 65536; i++) shadow[i] = pat(16'(i));
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
        check("rst_mem_strb", {31'd0, mem_strb}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_counts", {hit_cnt, miss_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Cold read miss then hit in the same line
        req(1'b0, 16'h1234, 8'h00, 1'b0, lat);
        check("t1_lat_lit", 32'(lat), 32'd34);
        check("t1_dout_lit", {24'd0, cpu_dout}, 32'h14);
        check("t1_miss_lit", {16'd0, miss_cnt}, 32'd1);
        req(1'b0, 16'h1235, 8'h00, 1'b1, lat);
        check("t2_lat_lit", 32'(lat), 32'd1);
        check("t2_dout_lit", {24'd0, cpu_dout}, 32'h15);
        check("t2_hit_lit", {16'd0, hit_cnt}, 32'd1);

        // Write hit stays in cache
        req(1'b1, 16'h1236, 8'hAB, 1'b0, lat);
        req(1'b0, 16'h1236, 8'h00, 1'b0, lat);
        check("t3_dout_lit", {24'd0, cpu_dout}, 32'hAB);
        check("t3_sdram_lit", {24'd0, sdram[16'h1236]}, 32'h16);

        // Conflict miss on a dirty line
        req(1'b0, 16'h5236, 8'h00, 1'b0, lat);
        check("t4_lat_lit", 32'(lat), 32'd66);
        check("t4_dout_lit", {24'd0, cpu_dout}, 32'h58);
        check("t4_sdram_lit", {24'd0, sdram[16'h1236]}, 32'hAB);

        // Write miss allocates, merges, no writeback
        req(1'b1, 16'h0008, 8'h5C, 1'b1, lat);
        check("t5_lat_lit", 32'(lat), 32'd34);
        req(1'b0, 16'h0008, 8'h00, 1'b0, lat);
        check("t5_dout_lit", {24'd0, cpu_dout}, 32'h5C);
        check("t5_sdram_lit", {24'd0, sdram[16'h0008]}, 32'h34);

        // Reset during the 4th allocate byte
        @(negedge clk);
        cpu_cs = 1'b1; cpu_wr_rd = 1'b0; cpu_addr = 16'h3000;
        @(posedge clk); #1; cpu_cs = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("t6_strb_before", {31'd0, mem_strb}, 32'd1);
        check("t6_addr_before", {16'd0, mem_addr}, 32'h3003);
        rst = 1'b1;
        #1;
        check("t6_strb_rst", {31'd0, mem_strb}, 32'd0);
        check("t6_rdy_rst", {31'd0, cpu_rdy}, 32'd1);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req(1'b0, 16'h3000, 8'h00, 1'b0, lat);
        check("t6_lat_lit", 32'(lat), 32'd34);
        check("t6_miss_lit", {16'd0, miss_cnt}, 32'd1);
        check("t6_hit_lit", {16'd0, hit_cnt}, 32'd0);
        req(1'b0, 16'h1234, 8'h00, 1'b0, lat);
        check("t6_relook_lat_lit", 32'(lat), 32'd34);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Direct-mapped, write-back, write-allocate cache controller between the CPU request port and the sdram memory model. It holds 32 lines of 8 bytes each, with tag, valid and dirty state per line. It drives the sdram's strobe-held, fixed-latency interface, which has no acknowledge. Accesses are single bytes on the CPU side; line fills and writebacks run as 8 sequential single-byte sdram accesses.

Parameters:
INDEX_BITS, 5, line index width (number of lines = 2^INDEX_BITS)
OFFSET_BITS, 3, byte offset width (line size = 2^OFFSET_BITS bytes)
MEM_DELAY, 2, sdram delay cycles; must match the sdram DELAY_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_cs  in  1  CPU request strobe; sampled only while cpu_rdy=1
cpu_wr_rd  in  1  1=write, 0=read
cpu_addr  in  16  CPU byte address
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data; valid when cpu_rdy rises after a read
cpu_rdy  out  1  1=idle/accepting, 0=busy
mem_addr  out  16  sdram Address
mem_wr_rd  out  1  sdram wr_rd
mem_strb  out  1  sdram mstrb
mem_dout  out  8  sdram DIn
mem_din  in  8  sdram DOut
hit_cnt  out  16  saturating hit counter
miss_cnt  out  16  saturating miss counter

Behaviour:
- Address split: tag = addr[15:8], index = addr[7:3], offset = addr[2:0] (defaults).
- Reset (async): cpu_rdy=1; cpu_dout=0; mem_strb=0; mem_addr=0; mem_wr_rd=0; mem_dout=0; hit_cnt=0; miss_cnt=0; all valid=0; all dirty=0; state=IDLE. Data and tag arrays need not clear.
- Reset mid-operation: any burst is abandoned immediately and mem_strb falls with rst. No partial line is left valid.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: cpu_rdy=1. When cpu_cs=1 at a clock edge, latch addr, wr_rd and din, go to COMPARE, and drop cpu_rdy.
- COMPARE: cpu_rdy=0. Hit means valid[index] and tag match.
  - Hit, read: cpu_dout <= data[index][offset].
  - Hit, write: data[index][offset] <= latched din; dirty[index] <= 1.
  - After a hit, return to IDLE.
  - hit_cnt increments once per request, only when the hit occurs in the first COMPARE pass.
  - Miss: miss_cnt increments. If valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- Hit latency: cpu_rdy is low for exactly 1 cycle. cpu_dout is valid in the cycle cpu_rdy returns to 1.
- sdram word access, used by WRITEBACK and ALLOCATE:
  - mem_addr, mem_wr_rd and mem_dout are stable for the whole access.
  - mem_strb is high for exactly MEM_DELAY+1 consecutive cycles, then low for 1 cycle: MEM_DELAY+2 cycles per byte.
  - Read data is captured from mem_din at the end of the strobe-low cycle.
  - mem_strb never stays high across two accesses.
- WRITEBACK: writes bytes 0..7 of the line to address {old_tag, index, 0..7}, ascending, mem_wr_rd=1. Then clears dirty and goes to ALLOCATE.
- ALLOCATE: reads bytes 0..7 from {new_tag, index, 0..7}, ascending, mem_wr_rd=0. Then sets tag, valid=1 and dirty=0, and returns to COMPARE, which now hits; the write-miss data merges there.
- Miss latency:
  - Clean miss: 1 + 8*(MEM_DELAY+2) + 1 = 34 cycles with cpu_rdy low.
  - Dirty miss: 66 cycles with cpu_rdy low.
- Counters: saturate at 0xFFFF and do not wrap.
- Outside bursts: mem_strb=0. Other mem_* outputs hold their last value.
- cpu_cs while cpu_rdy=0 is ignored; there is no queuing.

Test Plan:
1. Preload sdram 0x1230..0x1237 = 0x10..0x17; reset; read 0x1234 -> 8 read bursts at 0x1230..0x1237, each with mem_strb high 3 cycles; cpu_rdy low 34 cycles; cpu_dout=0x14; miss_cnt=1.
2. Then read 0x1235 -> cpu_rdy low exactly 1 cycle, no mem_strb, cpu_dout=0x15, hit_cnt=1.
3. Write 0xAB to 0x1236 -> hit, no sdram traffic; then read 0x1236 -> cpu_dout=0xAB; sdram 0x1236 still 0x16.
4. Read 0x5236 (same index 6, tag 0x52) -> writeback of 0x1230..0x1237 with 0x1236=0xAB, then fill from 0x5230; cpu_rdy low 66 cycles; sdram 0x1236=0xAB afterwards.
5. Write 0x5C to 0x0008 (cold line) -> allocate from 0x0008..0x000F, no writeback; read 0x0008 -> 0x5C; sdram 0x0008 unchanged.
6. Assert rst during the 4th ALLOCATE byte -> mem_strb=0 and cpu_rdy=1 immediately; the following read of the same address misses again (miss_cnt=1 after reset).
